traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Independent conflict and timing monitor on the receiving end of the six lamp outputs of the traffic controller.
- Each cycle, decodes the lamp vector into an observed phase and checks lamp validity, cross-direction conflicts, phase sequence and dwell times.
- Latches the first violation as a sticky fault and asserts force_flash so downstream lamp drivers can override to flashing red.

Parameters:
- GREEN_TIME, 60, required green dwell in cycles, same for both directions.
- YELLOW_TIME, 4, required yellow dwell in cycles.
- RED_TIME, 3, controller red hold in cycles.
- SAFE_TIME, 4, controller safe hold in cycles; minimum all-red dwell is RED_TIME+SAFE_TIME.
- CNT_W, 7, dwell counter width; must hold GREEN_TIME+1.

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- ns_green, ns_yellow, ns_red  in  1 each  observed north-south lamps.
- ew_green, ew_yellow, ew_red  in  1 each  observed east-west lamps.
- clear_fault  in  1  single-cycle pulse; clears the latched fault and starts resync.
- fault  out  1  sticky fault flag.
- fault_code  out  3  code of the first latched violation.
- phase  out  3  observed phase: 0 ALL_RED, 1 NS_G, 2 NS_Y, 3 EW_G, 4 EW_Y, 7 INVALID.
- force_flash  out  1  equals fault.

Behaviour:
- All outputs are registered. A violation on the inputs in cycle n gives fault=1 in cycle n+1.
- Reset values: fault=0, fault_code=0, phase=0, force_flash=0. FSM=M_ALLRED, dwell=0, last_dir=EW, so NS is expected to be served first.
- Lamp decode, per direction: exactly one lamp must be on, otherwise INVALID.
  - ALL_RED: both reds on.
  - NS_G / NS_Y: the NS lamp is on and ew_red is on.
  - EW_G / EW_Y: mirror of NS.
- Fault codes, priority highest first:
  - 1 LAMP: a direction is not one-hot.
  - 2 CONFLICT: both directions non-red.
  - 3 SEQ: illegal transition.
  - 4 YELLOW: yellow exit dwell != YELLOW_TIME.
  - 5 GREEN: green exit dwell != GREEN_TIME, or green still present after GREEN_TIME cycles, flagged on cycle GREEN_TIME+1 without waiting for exit.
  - 6 CLEAR: all-red exit dwell < RED_TIME+SAFE_TIME.
- Dwell counter: counts cycles the current phase has been seen, including the current cycle. Loads 1 on a phase change, saturates at all-ones. Exit checks use the count before the change.
- Legal transitions, with any phase allowed to hold:
  - ALL_RED->NS_G only if last_dir=EW; ALL_RED->EW_G only if last_dir=NS. last_dir updates on green entry.
  - NS_G->NS_Y->ALL_RED.
  - EW_G->EW_Y->ALL_RED.
  - Any other change raises SEQ.
- FSM states: M_ALLRED, M_NSG, M_NSY, M_EWG, M_EWY, M_FAULT, M_RESYNC.
  - Any violation in a checking state goes to M_FAULT.
  - M_FAULT holds fault_code; later violations are ignored.
  - clear_fault in M_FAULT: fault=0, go to M_RESYNC.
  - M_RESYNC: no checks. On the first ALL_RED cycle go to M_ALLRED with dwell=1; last_dir is reloaded on the next green, and both directions are accepted once.
- Simultaneous events: clear_fault in a cycle with a new violation leaves fault=1 with the new code. clear_fault outside M_FAULT is ignored.
- Reset mid-operation returns immediately to the reset values. After reset the first all-red is checked against the minimum only (15 ≥ 7 passes).
- phase output tracks the decode in every FSM state.

Optional Feature:
- TLM_CYCLE_COUNT_EN:
  - Defined: adds output cycle_count[15:0]. Reset 0; +1 on each legal EW_Y->ALL_RED transition (one full NS+EW cycle); wraps at 0xFFFF->0; holds while fault=1.
  - Undefined: port and logic absent.

Test Plan:
- Nominal: reset, then all-red 15, NS_G 60, NS_Y 4, all-red 7, EW_G 60, EW_Y 4, repeated 3 cycles -> fault=0 throughout; phase follows 0,1,2,0,3,4.
- Conflict: ns_green=1 and ew_green=1 together during NS_G (other lamps off) -> next cycle fault=1, fault_code=2, force_flash=1.
- Lamp: ns_green=1 and ns_red=1 with ew_red=1 -> fault_code=1, phase=7; a conflict in the same cycle still reports 1 by priority.
- Timing: NS_Y held 3 cycles then all-red -> fault_code=4 on the cycle after exit. Separately, NS_G held 61 cycles -> fault_code=5 on cycle 62.
- Sequence: NS_G, NS_Y, all-red 7, then NS_G again -> fault_code=3. NS_G straight to all-red -> fault_code=3.
- Clear and resync: from a fault, pulse clear_fault during EW_G -> fault=0, no checks until all-red, then the nominal sequence gives no fault. clear_fault together with a conflict -> fault stays 1, code=2. Reset asserted mid-green -> outputs return to their reset values immediately.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Watches the six lamp outputs of a two-direction traffic controller. Every cycle
// the lamp vector is decoded into an observed phase and checked for lamp validity,
// cross-direction conflicts, legal phase order and dwell times. The first
// violation is latched as a sticky fault, and force_flash tells the lamp drivers
// to go to flashing red.
// Optional build macro: TLM_CYCLE_COUNT_EN adds a 16-bit count of completed
// NS+EW cycles on output cycle_count.

module traffic_light_monitor #(
  parameter int GREEN_TIME  = 60,
  parameter int YELLOW_TIME = 4,
  parameter int RED_TIME    = 3,
  parameter int SAFE_TIME   = 4,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ns_green,
  input  logic        ns_yellow,
  input  logic        ns_red,
  input  logic        ew_green,
  input  logic        ew_yellow,
  input  logic        ew_red,
  input  logic        clear_fault,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [2:0]  phase,
  output logic        force_flash
`ifdef TLM_CYCLE_COUNT_EN
  ,
  output logic [15:0] cycle_count
`endif
);

  // state    | meaning
  // M_ALLRED | both reds seen; waiting for the next green
  // M_NSG    | north-south green being timed
  // M_NSY    | north-south yellow being timed
  // M_EWG    | east-west green being timed
  // M_EWY    | east-west yellow being timed
  // M_FAULT  | violation latched; only clear_fault is acted on
  // M_RESYNC | fault cleared; unchecked until the first all-red
  typedef enum logic [2:0] {
    M_ALLRED,
    M_NSG,
    M_NSY,
    M_EWG,
    M_EWY,
    M_FAULT,
    M_RESYNC
  } mon_state_t;

  typedef enum logic [2:0] {
    PH_ALLRED  = 3'd0,
    PH_NSG     = 3'd1,
    PH_NSY     = 3'd2,
    PH_EWG     = 3'd3,
    PH_EWY     = 3'd4,
    PH_INVALID = 3'd7
  } phase_t;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_LAMP     = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_SEQ      = 3'd3;
  localparam logic [2:0] FC_YELLOW   = 3'd4;
  localparam logic [2:0] FC_GREEN    = 3'd5;
  localparam logic [2:0] FC_CLEAR    = 3'd6;

  localparam logic [CNT_W-1:0] GREEN_CNT  = CNT_W'(GREEN_TIME);
  localparam logic [CNT_W-1:0] YELLOW_CNT = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] MIN_RED    = CNT_W'(RED_TIME + SAFE_TIME);
  localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);

  logic             ns_one;
  logic             ew_one;
  logic             lamp_bad;
  logic             conflict;
  phase_t           obs;

  mon_state_t       state_q;
  mon_state_t       state_d;
  phase_t           phase_q;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] dwell_d;
  logic             last_dir_q;
  logic             last_dir_d;
  logic             any_dir_q;
  logic             any_dir_d;
  logic             fault_q;
  logic             fault_d;
  logic [2:0]       code_q;
  logic [2:0]       code_d;

  logic             checking;
  logic             seq_bad;
  logic             yel_bad;
  logic             grn_bad;
  logic             clr_bad;
  logic [2:0]       viol_code;
  logic             dwell_restart;

  // Decode the raw lamps into one observed phase; anything not one-hot or with
  // both directions showing non-red decodes as INVALID.
  always_comb begin
    ns_one   = (ns_green & ~ns_yellow & ~ns_red) |
               (~ns_green & ns_yellow & ~ns_red) |
               (~ns_green & ~ns_yellow & ns_red);
    ew_one   = (ew_green & ~ew_yellow & ~ew_red) |
               (~ew_green & ew_yellow & ~ew_red) |
               (~ew_green & ~ew_yellow & ew_red);
    lamp_bad = ~(ns_one & ew_one);
    conflict = ns_one & ew_one & ~ns_red & ~ew_red;
    obs      = PH_INVALID;
    if (!lamp_bad && !conflict) begin
      if (ns_red && ew_red) begin
        obs = PH_ALLRED;
      end else if (!ns_red) begin
        obs = ns_green ? PH_NSG : PH_NSY;
      end else begin
        obs = ew_green ? PH_EWG : PH_EWY;
      end
    end
  end

  // Sequence and dwell checks against the phase being timed; exit checks use the
  // dwell count from before the change. Priority-encode into a single fault code.
  always_comb begin
    checking = 1'b0;
    seq_bad  = 1'b0;
    yel_bad  = 1'b0;
    grn_bad  = 1'b0;
    clr_bad  = 1'b0;
    case (state_q)
      M_ALLRED: begin
        checking = 1'b1;
        case (obs)
          PH_ALLRED: begin
          end
          PH_NSG: begin
            seq_bad = ~any_dir_q & (last_dir_q == DIR_NS);
            clr_bad = (dwell_q < MIN_RED);
          end
          PH_EWG: begin
            seq_bad = ~any_dir_q & (last_dir_q == DIR_EW);
            clr_bad = (dwell_q < MIN_RED);
          end
          default: seq_bad = 1'b1;
        endcase
      end
      M_NSG: begin
        checking = 1'b1;
        case (obs)
          PH_NSG:  grn_bad = (dwell_q >= GREEN_CNT);
          PH_NSY:  grn_bad = (dwell_q != GREEN_CNT);
          default: seq_bad = 1'b1;
        endcase
      end
      M_NSY: begin
        checking = 1'b1;
        case (obs)
          PH_NSY: begin
          end
          PH_ALLRED: yel_bad = (dwell_q != YELLOW_CNT);
          default:   seq_bad = 1'b1;
        endcase
      end
      M_EWG: begin
        checking = 1'b1;
        case (obs)
          PH_EWG:  grn_bad = (dwell_q >= GREEN_CNT);
          PH_EWY:  grn_bad = (dwell_q != GREEN_CNT);
          default: seq_bad = 1'b1;
        endcase
      end
      M_EWY: begin
        checking = 1'b1;
        case (obs)
          PH_EWY: begin
          end
          PH_ALLRED: yel_bad = (dwell_q != YELLOW_CNT);
          default:   seq_bad = 1'b1;
        endcase
      end
      default: begin
      end
    endcase

    viol_code = FC_NONE;
    if (lamp_bad) begin
      viol_code = FC_LAMP;
    end else if (conflict) begin
      viol_code = FC_CONFLICT;
    end else if (seq_bad) begin
      viol_code = FC_SEQ;
    end else if (yel_bad) begin
      viol_code = FC_YELLOW;
    end else if (grn_bad) begin
      viol_code = FC_GREEN;
    end else if (clr_bad) begin
      viol_code = FC_CLEAR;
    end
  end

  // Next-state logic: follow legal phase changes, latch the first violation,
  // and handle clear/resync. In M_FAULT only lamp and conflict errors can be
  // present, so a clear coinciding with one re-latches the new code.
  always_comb begin
    state_d       = state_q;
    fault_d       = fault_q;
    code_d        = code_q;
    last_dir_d    = last_dir_q;
    any_dir_d     = any_dir_q;
    dwell_restart = 1'b0;
    case (state_q)
      M_ALLRED: begin
        if (obs == PH_NSG) begin
          state_d = M_NSG;
        end else if (obs == PH_EWG) begin
          state_d = M_EWG;
        end
      end
      M_NSG: if (obs == PH_NSY) state_d = M_NSY;
      M_NSY: if (obs == PH_ALLRED) state_d = M_ALLRED;
      M_EWG: if (obs == PH_EWY) state_d = M_EWY;
      M_EWY: if (obs == PH_ALLRED) state_d = M_ALLRED;
      M_FAULT: begin
        if (clear_fault) begin
          if (viol_code != FC_NONE) begin
            code_d = viol_code;
          end else begin
            fault_d = 1'b0;
            state_d = M_RESYNC;
          end
        end
      end
      M_RESYNC: begin
        if (obs == PH_ALLRED) begin
          state_d       = M_ALLRED;
          any_dir_d     = 1'b1;
          dwell_restart = 1'b1;
        end
      end
      default: state_d = M_ALLRED;
    endcase

    if (checking) begin
      if (viol_code != FC_NONE) begin
        state_d = M_FAULT;
        fault_d = 1'b1;
        code_d  = viol_code;
      end else if (state_q == M_ALLRED && obs == PH_NSG) begin
        last_dir_d = DIR_NS;
        any_dir_d  = 1'b0;
      end else if (state_q == M_ALLRED && obs == PH_EWG) begin
        last_dir_d = DIR_EW;
        any_dir_d  = 1'b0;
      end
    end
  end

  // Dwell counts cycles the current observed phase has been present, saturating.
  always_comb begin
    if (dwell_restart || obs != phase_q) begin
      dwell_d = ONE_CNT;
    end else if (&dwell_q) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + ONE_CNT;
    end
  end

  // State and monitor registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= M_ALLRED;
      phase_q    <= PH_ALLRED;
      dwell_q    <= '0;
      last_dir_q <= DIR_EW;
      any_dir_q  <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= FC_NONE;
    end else begin
      state_q    <= state_d;
      phase_q    <= obs;
      dwell_q    <= dwell_d;
      last_dir_q <= last_dir_d;
      any_dir_q  <= any_dir_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
    end
  end

`ifdef TLM_CYCLE_COUNT_EN
  logic        count_inc;
  logic [15:0] cycle_count_q;

  assign count_inc = (state_q == M_EWY) && (obs == PH_ALLRED) &&
                     (viol_code == FC_NONE) && !fault_q;

  // Count completed NS+EW cycles; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count_q <= 16'd0;
    end else if (count_inc) begin
      cycle_count_q <= cycle_count_q + 16'd1;
    end
  end

  assign cycle_count = cycle_count_q;
`endif

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign phase       = phase_q;
  assign force_flash = fault_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: nominal cycling, each fault class,
// dwell boundaries, clear/resync behaviour and asynchronous reset.
`timescale 1ns/1ps
module tb_traffic_light_monitor;

  logic clk = 1'b0;
  logic reset;
  logic ns_green, ns_yellow, ns_red;
  logic ew_green, ew_yellow, ew_red;
  logic clear_fault;
  logic fault;
  logic [2:0] fault_code;
  logic [2:0] phase;
  logic force_flash;
`ifdef TLM_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  int errors = 0;
  int checks = 0;

  // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
  localparam logic [5:0] L_AR       = 6'b001_001;
  localparam logic [5:0] L_NSG      = 6'b100_001;
  localparam logic [5:0] L_NSY      = 6'b010_001;
  localparam logic [5:0] L_EWG      = 6'b001_100;
  localparam logic [5:0] L_EWY      = 6'b001_010;
  localparam logic [5:0] L_CONF     = 6'b100_100;
  localparam logic [5:0] L_LAMP     = 6'b101_001;
  localparam logic [5:0] L_LAMPCONF = 6'b110_100;

  traffic_light_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .ns_green    (ns_green),
    .ns_yellow   (ns_yellow),
    .ns_red      (ns_red),
    .ew_green    (ew_green),
    .ew_yellow   (ew_yellow),
    .ew_red      (ew_red),
    .clear_fault (clear_fault),
    .fault       (fault),
    .fault_code  (fault_code),
    .phase       (phase),
    .force_flash (force_flash)
`ifdef TLM_CYCLE_COUNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] l);
    {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red} = l;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input logic [5:0] l, input int n);
    drive(l);
    tick(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_fault = 1'b0;
    drive(L_AR);
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_fault = 1'b0;
    drive(L_NSG);
    tick(2);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b expected 0", fault); end
    checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", fault_code); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if (force_flash !== 1'b0) begin errors++; $display("FAIL reset_flash: got %0b expected 0", force_flash); end
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    logic [5:0] seg_l [6];
    int         seg_n [6];
    logic [2:0] seg_p [6];
    seg_l = '{L_NSG, L_NSY, L_AR, L_EWG, L_EWY, L_AR};
    seg_n = '{60, 4, 7, 60, 4, 7};
    seg_p = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd0};
    do_reset();
    drive(L_AR);
    for (int k = 0; k < 15; k++) begin
      tick(1);
      checks++;
      if (phase !== 3'd0 || fault !== 1'b0) begin
        errors++; $display("FAIL nominal_init: phase=%0d fault=%0b expected phase=0 fault=0", phase, fault);
      end
    end
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 6; s++) begin
        drive(seg_l[s]);
        for (int k = 0; k < seg_n[s]; k++) begin
          tick(1);
          checks++;
          if (phase !== seg_p[s] || fault !== 1'b0) begin
            errors++;
            $display("FAIL nominal c%0d s%0d k%0d: phase=%0d fault=%0b expected phase=%0d fault=0",
                     c, s, k, phase, fault, seg_p[s]);
          end
        end
      end
    end
`ifdef TLM_CYCLE_COUNT_EN
    checks++; if (cycle_count !== 16'd3) begin errors++; $display("FAIL nominal_cycle_count: got %0d expected 3", cycle_count); end
`endif
  endtask

  task automatic test_conflict();
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 5);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL conflict_pre: fault=%0b expected 0", fault); end
    run(L_CONF, 1);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL conflict_fault: got %0b expected 1", fault); end
    checks++; if (fault_code !== 3'd2) begin errors++; $display("FAIL conflict_code: got %0d expected 2", fault_code); end
    checks++; if (force_flash !== 1'b1) begin errors++; $display("FAIL conflict_flash: got %0b expected 1", force_flash); end
    checks++; if (phase !== 3'd7) begin errors++; $display("FAIL conflict_phase: got %0d expected 7", phase); end
  endtask

  task automatic test_lamp();
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 3);
    run(L_LAMP, 1);
    checks++; if (fault_code !== 3'd1 || fault !== 1'b1) begin errors++; $display("FAIL lamp_code: code=%0d fault=%0b expected 1/1", fault_code, fault); end
    checks++; if (phase !== 3'd7) begin errors++; $display("FAIL lamp_phase: got %0d expected 7", phase); end
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 3);
    run(L_LAMPCONF, 1);
    checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL lamp_priority: got %0d expected 1", fault_code); end
  endtask

  task automatic test_timing();
    // Short yellow.
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 60);
    run(L_NSY, 3);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL yellow_pre: fault=%0b expected 0", fault); end
    run(L_AR, 1);
    checks++; if (fault_code !== 3'd4 || fault !== 1'b1) begin errors++; $display("FAIL yellow_short: code=%0d fault=%0b expected 4/1", fault_code, fault); end
    // Green overstay: exactly GREEN_TIME is fine, one more is flagged.
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 60);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL green_60: fault=%0b expected 0", fault); end
    run(L_NSG, 1);
    checks++; if (fault_code !== 3'd5 || fault !== 1'b1) begin errors++; $display("FAIL green_long: code=%0d fault=%0b expected 5/1", fault_code, fault); end
    // Green short on exit.
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 59);
    run(L_NSY, 1);
    checks++; if (fault_code !== 3'd5 || fault !== 1'b1) begin errors++; $display("FAIL green_short: code=%0d fault=%0b expected 5/1", fault_code, fault); end
    // All-red one cycle short between directions.
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 60);
    run(L_NSY, 4);
    run(L_AR, 6);
    run(L_EWG, 1);
    checks++; if (fault_code !== 3'd6 || fault !== 1'b1) begin errors++; $display("FAIL clear_short: code=%0d fault=%0b expected 6/1", fault_code, fault); end
    // First all-red after reset: 7 passes, 6 fails.
    do_reset();
    run(L_AR, 7);
    run(L_NSG, 1);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_allred_7: fault=%0b expected 0", fault); end
    do_reset();
    run(L_AR, 6);
    run(L_NSG, 1);
    checks++; if (fault_code !== 3'd6 || fault !== 1'b1) begin errors++; $display("FAIL reset_allred_6: code=%0d fault=%0b expected 6/1", fault_code, fault); end
  endtask

  task automatic test_sequence();
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 60);
    run(L_NSY, 4);
    run(L_AR, 7);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL seq_pre: fault=%0b expected 0", fault); end
    run(L_NSG, 1);
    checks++; if (fault_code !== 3'd3 || fault !== 1'b1) begin errors++; $display("FAIL seq_ns_twice: code=%0d fault=%0b expected 3/1", fault_code, fault); end
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 10);
    run(L_AR, 1);
    checks++; if (fault_code !== 3'd3) begin errors++; $display("FAIL seq_green_to_red: got %0d expected 3", fault_code); end
    do_reset();
    run(L_AR, 15);
    run(L_EWG, 1);
    checks++; if (fault_code !== 3'd3) begin errors++; $display("FAIL seq_ew_first: got %0d expected 3", fault_code); end
  endtask

  task automatic test_clear_resync();
    logic [5:0] seg_l [6];
    int         seg_n [6];
    seg_l = '{L_NSG, L_NSY, L_AR, L_EWG, L_EWY, L_AR};
    seg_n = '{60, 4, 7, 60, 4, 7};
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 5);
    run(L_CONF, 1);
    checks++; if (fault_code !== 3'd2) begin errors++; $display("FAIL resync_first: got %0d expected 2", fault_code); end
    run(L_LAMP, 1);
    checks++; if (fault_code !== 3'd2 || fault !== 1'b1) begin errors++; $display("FAIL resync_sticky: code=%0d fault=%0b expected 2/1", fault_code, fault); end
    run(L_EWG, 3);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    checks++; if (fault !== 1'b0 || force_flash !== 1'b0) begin errors++; $display("FAIL resync_clear: fault=%0b flash=%0b expected 0/0", fault, force_flash); end
    run(L_EWG, 20);
    checks++; if (fault !== 1'b0 || phase !== 3'd3) begin errors++; $display("FAIL resync_ewg: fault=%0b phase=%0d expected 0/3", fault, phase); end
    run(L_EWY, 2);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL resync_ewy: fault=%0b expected 0", fault); end
    run(L_AR, 7);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL resync_ar: fault=%0b expected 0", fault); end
    for (int s = 0; s < 6; s++) begin
      run(seg_l[s], seg_n[s]);
      checks++;
      if (fault !== 1'b0) begin errors++; $display("FAIL resync_nominal s%0d: fault=%0b code=%0d expected 0", s, fault, fault_code); end
    end
    run(L_NSG, 1);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL resync_next_ns: fault=%0b code=%0d expected 0", fault, fault_code); end
  endtask

  task automatic test_clear_conflict();
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 5);
    run(L_AR, 1);
    checks++; if (fault_code !== 3'd3) begin errors++; $display("FAIL clrconf_first: got %0d expected 3", fault_code); end
    tick(1);
    clear_fault = 1'b1;
    drive(L_CONF);
    tick(1);
    clear_fault = 1'b0;
    checks++; if (fault !== 1'b1 || fault_code !== 3'd2) begin errors++; $display("FAIL clrconf_new: fault=%0b code=%0d expected 1/2", fault, fault_code); end
    run(L_AR, 2);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL clrconf_hold: fault=%0b expected 1", fault); end
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL clrconf_clear: fault=%0b expected 0", fault); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(L_AR, 15);
    run(L_NSG, 5);
    run(L_CONF, 1);
    run(L_NSG, 1);
    checks++; if (fault !== 1'b1 || phase !== 3'd1) begin errors++; $display("FAIL midreset_pre: fault=%0b phase=%0d expected 1/1", fault, phase); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (fault !== 1'b0 || force_flash !== 1'b0) begin errors++; $display("FAIL midreset_fault: fault=%0b flash=%0b expected 0/0", fault, force_flash); end
    checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL midreset_code: got %0d expected 0", fault_code); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL midreset_phase: got %0d expected 0", phase); end
    drive(L_AR);
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_fault = 1'b0;
    drive(L_AR);
    test_reset();
    test_nominal();
    test_conflict();
    test_lamp();
    test_timing();
    test_sequence();
    test_clear_resync();
    test_clear_conflict();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
